// File: rtl/sm3_message_expansion_if.sv
// Signal bundle between the SM3 block buffer, the message expansion unit and the compression function.
// The master side is the expansion unit; the slave side is its block source and round consumer.
interface sm3_message_expansion_if;
    logic         block_valid_in;
    logic         block_ready_out;
    logic [511:0] block_in;
    logic         first_block_in;
    logic         start_out;
    logic [5:0]   index_j_out;
    logic [31:0]  word_expanded_out;
    logic [31:0]  word_expanded_p_out;
    logic         is_1st_msg_block_out;
    logic         done_out;

    modport master (
        input  block_valid_in, block_in, first_block_in,
        output block_ready_out, start_out, index_j_out, word_expanded_out,
               word_expanded_p_out, is_1st_msg_block_out, done_out
    );

    modport slave (
        output block_valid_in, block_in, first_block_in,
        input  block_ready_out, start_out, index_j_out, word_expanded_out,
               word_expanded_p_out, is_1st_msg_block_out, done_out
    );
endinterface

// File: rtl/sm3_message_expansion.sv
// SM3 message expansion: takes one 512-bit block and streams W_j / W'_j for j = 0..63,
// one pair per cycle, behind a start pulse and a one-cycle compression load slot.
module sm3_message_expansion #(
    parameter int ROUNDS = 64
) (
    input logic                     clk_in,
    input logic                     reset_in,
    sm3_message_expansion_if.master bus
);
    localparam logic [5:0] LAST_J = 6'(ROUNDS - 1);

    typedef enum logic [1:0] {IDLE, START, HOLD, STREAM} state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] win [16];
    logic [5:0]  idx;
    logic        first_q;
    logic        done_q;
    logic        live;
    logic        ready;
    logic        accept;
    logic        advance;
    logic [31:0] new_word;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] p1(input logic [31:0] x);
        return x ^ rotl(x, 15) ^ rotl(x, 23);
    endfunction

    // live holds ready low until the first edge after reset is released.
    assign ready    = live && (state == IDLE);
    assign accept   = ready && bus.block_valid_in;
    assign advance  = (state == STREAM) && (idx != LAST_J);
    assign new_word = p1(win[0] ^ win[7] ^ rotl(win[13], 15)) ^ rotl(win[3], 7) ^ win[10];

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        // NOTE: assigning the default first means no path leaves state_next unassigned, so no latch.
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = START;
            START:   state_next = HOLD;
            HOLD:    state_next = STREAM;
            STREAM:  if (idx == LAST_J) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            // NOTE: the window is a register bank, not RAM, so it can and must clear on reset.
            win     <= '{default: '0};
            idx     <= '0;
            first_q <= 1'b0;
            done_q  <= 1'b0;
            live    <= 1'b0;
        end else begin
            live   <= 1'b1;
            done_q <= (state == STREAM) && (idx == LAST_J);
            if (accept) begin
                for (int k = 0; k < 16; k++) win[k] <= bus.block_in[511 - 32 * k -: 32];
                idx     <= '0;
                first_q <= bus.first_block_in;
            end else if (advance) begin
                // NOTE: non-blocking lets every win[k] take the pre-edge win[k+1] in one pass.
                for (int k = 0; k < 15; k++) win[k] <= win[k + 1];
                win[15] <= new_word;
                idx     <= idx + 6'd1;
            end
        end
    end

    assign bus.block_ready_out      = ready;
    assign bus.start_out            = (state == START);
    assign bus.index_j_out          = idx;
    assign bus.word_expanded_out    = win[0];
    assign bus.word_expanded_p_out  = win[0] ^ win[4];
    assign bus.is_1st_msg_block_out = first_q;
    assign bus.done_out             = done_q;
endmodule

// File: doc/sm3_message_expansion.md
Name: sm3_message_expansion

Overview:
- Producer side of the SM3 compression round interface.
- Accepts one padded 512-bit message block per transaction, expands it on the fly into W_j and W'_j for j = 0..63, and streams one word pair per cycle to the compression function.
- Drives the compression function's start, index and first-block controls with a fixed cycle alignment. Sits between the padding/block buffer and the compression function.

Parameters:
- ROUNDS, 64, number of j indices streamed per block. Fixed by SM3; only 64 is supported.

Ports:
- clk_in  input  1  system clock; all logic on the rising edge.
- reset_in  input  1  asynchronous, active-high reset.
- block_valid_in  input  1  block_in and first_block_in are valid.
- block_ready_out  output  1  block accepted on a cycle where block_valid_in && block_ready_out.
- block_in  input  512  padded block; bits [511:480] = W_0, ..., [31:0] = W_15.
- first_block_in  input  1  block is the first of its message (IV load).
- start_out  output  1  one-cycle start pulse to the compression function.
- index_j_out  output  6  current round index j.
- word_expanded_out  output  32  W_j.
- word_expanded_p_out  output  32  W'_j = W_j ^ W_{j+4}.
- is_1st_msg_block_out  output  1  latched first_block_in, held for the whole transaction.
- done_out  output  1  one-cycle pulse after the j=63 pair is presented.

Behaviour:
- Reset (async, reset_in=1): state IDLE, window cleared.
  - Outputs: block_ready_out=0, start_out=0, index_j_out=0, word outputs=0, is_1st_msg_block_out=0, done_out=0.
  - Deasserting reset returns to IDLE; block_ready_out rises on the first clock edge after deassertion.
  - Reset mid-stream aborts the stream immediately; no done_out.
- Window: 16 x 32-bit shift register win[0..15] holding W_j..W_{j+15}.
  - Outputs: word_expanded_out = win[0]; word_expanded_p_out = win[0] ^ win[4].
  - Both are registered-state derived, with no combinational path from inputs.
- Expansion: new = P1(win[0] ^ win[7] ^ ROTL(win[13],15)) ^ ROTL(win[3],7) ^ win[10].
  - P1(x) = x ^ ROTL(x,15) ^ ROTL(x,23).
  - All arithmetic is 32-bit XOR/rotate; no carries.
  - On each advance: win[k] <= win[k+1], win[15] <= new.
  - Words beyond W_67 are computed but never presented; no special casing is needed.
- FSM IDLE -> START -> HOLD -> STREAM -> IDLE:
  - IDLE: block_ready_out=1. On accept, load win from block_in, latch first_block_in, go to START.
  - START (cycle S): start_out=1, index_j_out=0, W_0 presented, window holds.
  - HOLD (cycle S+1): index_j_out=0, W_0/W'_0 held; this is the compression load cycle.
  - STREAM (cycles S+2 .. S+65): on cycle S+2+j, index_j_out=j with W_j, W'_j.
    - Window and index advance at the end of each STREAM cycle.
    - After j=63 go IDLE.
  - done_out=1 on cycle S+66, the first IDLE cycle; block_ready_out is also 1 on that cycle.
- Throughput: one block per 67 cycles, from accept cycle A (S = A+1) to the next possible accept.
- block_ready_out=0 in START, HOLD and STREAM. block_valid_in is ignored there and block_in need not be held after accept.
- index_j_out holds 63 and the words hold their last values while IDLE, until the next START; there is no wrap to 0 in IDLE.
- Only in START does is_1st_msg_block_out update, to the latched value; it is stable from S through S+65.
- No downstream back-pressure: the consumer must take one pair per cycle.

Test Plan:
- SM3 "abc" block (61626380, 14 x 00000000, 00000018), first_block_in=1, accepted on cycle A:
  - start_out pulses on A+1.
  - index_j_out=0, word_expanded_out=61626380, word_expanded_p_out=61626380 on A+1..A+3.
  - index_j_out=16 with W_16=9092e200 on A+19.
  - index_j_out=63 on A+66; done_out on A+67.
- Full "abc" stream vs golden model: all 64 W_j and W'_j match, and W'_j = W_j ^ W_{j+4} for every j.
  - Integrated with the compression function, the digest = 66c7f0f4 62eeedd9 d1f2d46b dc10e4e2 4167c487 5cf2f7a2 297da02b 8f4ba8e0.
- Back-to-back blocks, block_valid_in held high, first_block_in=1 then 0:
  - Second accept occurs exactly on the done_out cycle.
  - is_1st_msg_block_out is 1 during the first stream and 0 during the second.
  - No gap or duplicate index between the two streams.
- block_valid_in toggled with random block_in during STREAM: no effect on the stream; block_ready_out stays 0.
- reset_in asserted asynchronously at j=30 (mid-cycle):
  - All outputs go to reset values immediately with no done_out.
  - After release, a new block streams correctly from j=0.
